hit_judge: RTL

//  Timing judge for the 4-lane arrow game. Tracks every arrow spawned by the timer (arrows[3:0]),

---
 rtl/hit_judge.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/hit_judge.sv
// Timing judge for the 4-lane arrow game.
// Each lane keeps a small FIFO of arrow ages, counted in frames. Key presses
// grade the oldest arrow in a lane as PERFECT or GOOD. An arrow that is too old
// is timed out as a MISS. Score, combo and the last judgement are registered.
module hit_judge #(
  parameter int          DEPTH         = 4,
  parameter int          AGE_W         = 8,
  parameter int          TRAVEL_FRAMES = 120,
  parameter int          WIN_PERFECT   = 3,
  parameter int          WIN_GOOD      = 8,
  parameter int          PTS_PERFECT   = 2,
  parameter int          PTS_GOOD      = 1,
  parameter logic [7:0]  KEY_L         = 8'h6B,
  parameter logic [7:0]  KEY_D         = 8'h72,
  parameter logic [7:0]  KEY_U         = 8'h75,
  parameter logic [7:0]  KEY_R         = 8'h74
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [3:0]  arrows,
  input  logic [7:0]  keyCode,
  input  logic        press,
  output logic [15:0] score,
  output logic [7:0]  combo,
  output logic        judge_valid,
  output logic [1:0]  judge_code,
  output logic [1:0]  judge_lane,
  output logic        overflow
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [AGE_W-1:0] AGE_ZERO   = {AGE_W{1'b0}};
  localparam logic [AGE_W-1:0] AGE_MAX    = {AGE_W{1'b1}};
  localparam logic [AGE_W-1:0] EARLY_LIM  = AGE_W'(TRAVEL_FRAMES - WIN_GOOD);
  localparam logic [AGE_W-1:0] LATE_LIM   = AGE_W'(TRAVEL_FRAMES + WIN_GOOD);
  localparam logic [AGE_W-1:0] PERF_LO    = AGE_W'(TRAVEL_FRAMES - WIN_PERFECT);
  localparam logic [AGE_W-1:0] PERF_HI    = AGE_W'(TRAVEL_FRAMES + WIN_PERFECT);
  localparam logic [1:0]       CODE_PERF  = 2'd1;
  localparam logic [1:0]       CODE_GOOD  = 2'd2;
  localparam logic [1:0]       CODE_MISS  = 2'd3;

  // Map a scan code to {mapped, lane}. Codes that are not mapped return 3'b000.
  function automatic logic [2:0] key_map_f(input logic [7:0] code);
    logic [2:0] r;
    case (code)
      KEY_L:   r = 3'b100;
      KEY_D:   r = 3'b101;
      KEY_U:   r = 3'b110;
      KEY_R:   r = 3'b111;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  // History registers used for edge detection.
  logic             frame_clk_q;
  logic [3:0]       arrows_q;
  logic             press_q;
  logic [7:0]       key_code_q;

  // Per-lane age FIFOs. Entry 0 is the oldest arrow, and slots past count are kept at zero.
  logic [AGE_W-1:0] ages_q [4][DEPTH];
  logic [AGE_W-1:0] ages_d [4][DEPTH];
  logic [AGE_W-1:0] inc_s  [4][DEPTH];
  logic [CNT_W-1:0] count_q [4];
  logic [CNT_W-1:0] count_d [4];
  logic [CNT_W-1:0] cnt_pop_s [4];

  logic [15:0]      score_q, score_d;
  logic [7:0]       combo_q, combo_d;
  logic             judge_valid_q;
  logic [1:0]       judge_code_q, judge_code_d;
  logic [1:0]       judge_lane_q, judge_lane_d;
  logic             overflow_q;

  logic             frame_tick_s;
  logic [3:0]       spawn_s;
  logic             key_evt_s;
  logic [2:0]       key_map_s;
  logic [3:0]       lane_valid_s, key_on_lane_s, hit_s;
  logic [3:0]       miss_s, perfect_s, good_s, pop_s, drop_s;
  logic [4:0]       pts_s;
  logic [2:0]       hits_s;
  logic [16:0]      score_sum_s;
  logic [8:0]       combo_sum_s;

  // Detect edges and grade the head entry of each lane.
  // A MISS on a lane blocks a key hit on the same lane.
  always_comb begin
    frame_tick_s = frame_clk & ~frame_clk_q;
    spawn_s      = arrows & ~arrows_q;
    key_evt_s    = press & (~press_q | (keyCode != key_code_q));
    key_map_s    = key_map_f(keyCode);
    for (int l = 0; l < 4; l++) begin
      lane_valid_s[l]  = (count_q[l] != {CNT_W{1'b0}});
      miss_s[l]        = lane_valid_s[l] && (ages_q[l][0] > LATE_LIM);
      key_on_lane_s[l] = key_evt_s && key_map_s[2] && (key_map_s[1:0] == 2'(l));
      hit_s[l]         = key_on_lane_s[l] && lane_valid_s[l] && !miss_s[l]
                         && (ages_q[l][0] >= EARLY_LIM);
      perfect_s[l]     = hit_s[l] && (ages_q[l][0] >= PERF_LO) && (ages_q[l][0] <= PERF_HI);
      good_s[l]        = hit_s[l] && !perfect_s[l];
      pop_s[l]         = miss_s[l] | hit_s[l];
    end
  end

  // Compute the next FIFO state in three steps: age the valid entries on a
  // frame tick, shift out a popped head, then append a new arrow at age 0.
  always_comb begin
    for (int l = 0; l < 4; l++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (CNT_W'(e) < count_q[l]) begin
          inc_s[l][e] = (frame_tick_s && (ages_q[l][e] != AGE_MAX))
                        ? ages_q[l][e] + AGE_W'(1) : ages_q[l][e];
        end else begin
          inc_s[l][e] = AGE_ZERO;
        end
      end
      for (int e = 0; e < DEPTH - 1; e++) begin
        ages_d[l][e] = pop_s[l] ? inc_s[l][e+1] : inc_s[l][e];
      end
      ages_d[l][DEPTH-1] = pop_s[l] ? AGE_ZERO : inc_s[l][DEPTH-1];
      cnt_pop_s[l] = count_q[l] - CNT_W'(pop_s[l]);
      count_d[l]   = cnt_pop_s[l];
      drop_s[l]    = 1'b0;
      if (spawn_s[l]) begin
        if (cnt_pop_s[l] < CNT_W'(DEPTH)) begin
          for (int e = 0; e < DEPTH; e++) begin
            ages_d[l][e] = (CNT_W'(e) == cnt_pop_s[l]) ? AGE_ZERO : ages_d[l][e];
          end
          count_d[l] = cnt_pop_s[l] + CNT_W'(1);
        end else begin
          drop_s[l] = 1'b1;
        end
      end else begin
        count_d[l] = cnt_pop_s[l];
      end
    end
  end

  // Add up the points for this cycle and update the combo.
  // The judgement output reports the lowest-numbered lane that was judged.
  always_comb begin
    pts_s        = 5'd0;
    hits_s       = 3'd0;
    judge_code_d = judge_code_q;
    judge_lane_d = judge_lane_q;
    for (int l = 0; l < 4; l++) begin
      pts_s  = pts_s + (perfect_s[l] ? 5'(PTS_PERFECT) : 5'd0)
                     + (good_s[l]    ? 5'(PTS_GOOD)    : 5'd0);
      hits_s = hits_s + (hit_s[l] ? 3'd1 : 3'd0);
    end
    for (int l = 3; l >= 0; l--) begin
      judge_lane_d = pop_s[l] ? 2'(l) : judge_lane_d;
      judge_code_d = pop_s[l] ? (miss_s[l] ? CODE_MISS : (perfect_s[l] ? CODE_PERF : CODE_GOOD))
                              : judge_code_d;
    end
    score_sum_s = {1'b0, score_q} + 17'(pts_s);
    score_d     = score_sum_s[16] ? 16'hFFFF : score_sum_s[15:0];
    combo_sum_s = {1'b0, combo_q} + 9'(hits_s);
    if (|miss_s) begin
      combo_d = 8'h00;
    end else begin
      combo_d = combo_sum_s[8] ? 8'hFF : combo_sum_s[7:0];
    end
  end

  // State update. Reset takes priority over every event and clears all state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_clk_q   <= 1'b0;
      arrows_q      <= 4'd0;
      press_q       <= 1'b0;
      key_code_q    <= 8'h00;
      score_q       <= 16'h0000;
      combo_q       <= 8'h00;
      judge_valid_q <= 1'b0;
      judge_code_q  <= 2'd0;
      judge_lane_q  <= 2'd0;
      overflow_q    <= 1'b0;
      for (int l = 0; l < 4; l++) begin
        count_q[l] <= {CNT_W{1'b0}};
        for (int e = 0; e < DEPTH; e++) begin
          ages_q[l][e] <= AGE_ZERO;
        end
      end
    end else begin
      frame_clk_q   <= frame_clk;
      arrows_q      <= arrows;
      press_q       <= press;
      key_code_q    <= keyCode;
      score_q       <= score_d;
      combo_q       <= combo_d;
      judge_valid_q <= |pop_s;
      judge_code_q  <= judge_code_d;
      judge_lane_q  <= judge_lane_d;
      overflow_q    <= overflow_q | (|drop_s);
      for (int l = 0; l < 4; l++) begin
        count_q[l] <= count_d[l];
        for (int e = 0; e < DEPTH; e++) begin
          ages_q[l][e] <= ages_d[l][e];
        end
      end
    end
  end

  assign score       = score_q;
  assign combo       = combo_q;
  assign judge_valid = judge_valid_q;
  assign judge_code  = judge_code_q;
  assign judge_lane  = judge_lane_q;
  assign overflow    = overflow_q;

endmodule
